// File: rtl/hazard_pkg.sv
// Purpose: shared state encoding, constants and load-use compare for the hazard controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Width of the remaining-bubbles counter; holds LOAD_LAT-1, at most 6.
    localparam int REM_W = 3;

    // A load in EX writes a register that the ID instruction reads.
    // $0 is hard-wired, so it never carries a dependency.
    function automatic logic load_use_hazard(
        input logic       id_valid,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt,
        input logic       ex_memread,
        input logic [4:0] ex_rt
    );
        return id_valid & ex_memread & (ex_rt != REG_ZERO) &
               ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Purpose: bundles the ID/EX hazard inputs and the pipeline enable/flush controls.
// Latency: n/a (wires only).
// Backpressure: n/a; pc_write/ifid_write low is the stall indication to the pipeline.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             ex_jump;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: supplies stage fields, consumes the controls.
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt,
        output ex_memread, ex_rt, ex_branch_taken, ex_jump,
        input  pc_write, ifid_write, ifid_flush, idex_flush,
        input  hz_state, stall_cnt, flush_cnt
    );

    // Hazard controller side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt,
        input  ex_memread, ex_rt, ex_branch_taken, ex_jump,
        output pc_write, ifid_write, ifid_flush, idex_flush,
        output hz_state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Purpose: event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects an inc one cycle after it is sampled.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, hold once every bit is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: load-use stall and branch/jump squash control for the 5-stage pipeline.
// Latency: controls are combinational; state and counters update on the next edge.
// Backpressure: holds PC and IF/ID for LOAD_LAT cycles per load-use hazard.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    // Bubbles still owed after the first one, inserted while in RUN.
    localparam logic [REM_W-1:0] REM_INIT    = REM_W'(LOAD_LAT - 1);
    localparam bit               MULTI_CYCLE = (LOAD_LAT > 1);

    hz_state_t        state;
    logic [REM_W-1:0] remaining;
    logic             hazard;
    logic             redirect;
    logic             stall_inc;
    logic             flush_inc;

    assign hazard = load_use_hazard(hz.id_valid, hz.id_rs, hz.id_rt, hz.id_uses_rt,
                                    hz.ex_memread, hz.ex_rt);

    assign redirect = hz.ex_branch_taken | hz.ex_jump;

    assign hz.hz_state = state;

    // Pipeline controls: reset squashes everything, then a redirect beats any
    // stall because the ID instruction is on the wrong path. In STALL the load
    // has already left EX, so the stall comes from the state rather than hazard.
    always_comb begin
        hz.pc_write   = 1'b1;
        hz.ifid_write = 1'b1;
        hz.ifid_flush = 1'b0;
        hz.idex_flush = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        if (rst) begin
            hz.pc_write   = 1'b0;
            hz.ifid_write = 1'b0;
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
        end else if (redirect) begin
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
            flush_inc     = 1'b1;
        end else if ((state == HZ_STALL) || hazard) begin
            hz.pc_write   = 1'b0;
            hz.ifid_write = 1'b0;
            hz.idex_flush = 1'b1;
            stall_inc     = 1'b1;
        end
    end

    // Stall sequencer: RUN inserts the first bubble, STALL inserts the rest and
    // returns to RUN on the last one or on any redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HZ_RUN;
            remaining <= '0;
        end else begin
            case (state)
                HZ_RUN: begin
                    if (!redirect && hazard && MULTI_CYCLE) begin
                        state     <= HZ_STALL;
                        remaining <= REM_INIT;
                    end
                end
                HZ_STALL: begin
                    if (redirect) begin
                        state     <= HZ_RUN;
                        remaining <= '0;
                    end else begin
                        remaining <= remaining - REM_W'(1);
                        if (remaining == REM_W'(1)) begin
                            state <= HZ_RUN;
                        end
                    end
                end
                default: begin
                    state     <= HZ_RUN;
                    remaining <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (hz.flush_cnt)
    );

endmodule
